tone_detector: RTL and testbench

TONE_DETECTOR -- requirements
Module: tone_detector

---
 rtl/tone_detector.sv | 188 ++++++++++++++++++
 tb/tb_tone_detector.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tone_detector.sv
// -----------------------------------------------------------------------------
// tone_detector
//
// Measures the period and peak amplitude of a periodic waveform. It waits for a
// rising zero crossing, then counts accepted samples across NCROSS further
// rising crossings and reports the span (r_period) together with the largest
// |sample| seen in the window (r_peak). If a window stalls for TIMEOUT accepted
// samples without a crossing, it is cut short and flagged with r_timeout.
//
// Optional feature: define TONE_DET_HYST_EN to replace plain sign-change
// detection with a hysteresis detector. An accepted sample < -HYST arms it, and
// an armed sample >= +HYST is a crossing, which disarms it.
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   s_data    in   [DATA_W-1:0] signed sample
//   s_valid   in   sample offered
//   s_ready   out  sample accepted when s_valid & s_ready (low while reporting)
//   r_valid   out  result available
//   r_ready   in   result consumed when r_valid & r_ready
//   r_period  out  [CNT_W-1:0] accepted samples spanning NCROSS periods
//   r_peak    out  [DATA_W-1:0] unsigned peak magnitude over the window
//   r_timeout out  window ended by timeout rather than by the last crossing
// -----------------------------------------------------------------------------
module tone_detector #(
   parameter int DATA_W  = 16,
   parameter int NCROSS  = 8,
   parameter int CNT_W   = 24,
   parameter int TIMEOUT = 65535,
   parameter int HYST    = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              r_valid,
   input  logic              r_ready,
   output logic [CNT_W-1:0]  r_period,
   output logic [DATA_W-1:0] r_peak,
   output logic              r_timeout
);

   localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   // Out-of-range parameters show up as this named scope in the elaborated
   // hierarchy; legal configurations produce nothing here.
   if (HYST < 0 || NCROSS < 1 || NCROSS > 255 || TIMEOUT < 1) begin : g_illegal_parameters
   end

   typedef enum logic [1:0] {ST_IDLE, ST_MEASURE, ST_REPORT} state_t;

   state_t             state_q,     state_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic [TO_W-1:0]    since_q,     since_d;
   logic [7:0]         ncross_q,    ncross_d;
   logic [DATA_W-1:0]  peak_q,      peak_d;
   logic               armed_q,     armed_d;
   logic [CNT_W-1:0]   r_period_q,  r_period_d;
   logic [DATA_W-1:0]  r_peak_q,    r_peak_d;
   logic               r_timeout_q, r_timeout_d;

   logic [DATA_W-1:0]  abs_val;
   logic [DATA_W-1:0]  peak_new;
   logic [CNT_W-1:0]   cnt_inc;
   logic [TO_W-1:0]    since_inc;
   logic               crossing;
   logic               armed_next;

`ifdef TONE_DET_HYST_EN
   localparam logic signed [DATA_W-1:0] HYST_POS = DATA_W'(HYST);
   localparam logic signed [DATA_W-1:0] HYST_NEG = -HYST_POS;
`endif

   always_comb begin
      // Magnitude as unsigned DATA_W: the most negative code maps to 2^(DATA_W-1).
      abs_val   = s_data[DATA_W-1] ? (~s_data + {{(DATA_W-1){1'b0}}, 1'b1}) : s_data;
      peak_new  = (abs_val > peak_q) ? abs_val : peak_q;
      cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      since_inc = since_q + {{(TO_W-1){1'b0}}, 1'b1};
`ifdef TONE_DET_HYST_EN
      crossing   = armed_q && ($signed(s_data) >= HYST_POS);
      armed_next = armed_q;
      if (crossing) begin
         armed_next = 1'b0;
      end else if ($signed(s_data) < HYST_NEG) begin
         armed_next = 1'b1;
      end
`else
      // armed_q here simply records "previous accepted sample was negative".
      crossing   = armed_q && !s_data[DATA_W-1];
      armed_next = s_data[DATA_W-1];
`endif
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      since_d     = since_q;
      ncross_d    = ncross_q;
      peak_d      = peak_q;
      armed_d     = armed_q;
      r_period_d  = r_period_q;
      r_peak_d    = r_peak_q;
      r_timeout_d = r_timeout_q;

      case (state_q)
         ST_IDLE: begin
            if (s_valid) begin
               armed_d = armed_next;
               if (crossing) begin
                  state_d  = ST_MEASURE;
                  cnt_d    = '0;
                  since_d  = '0;
                  ncross_d = '0;
                  peak_d   = abs_val;
               end
            end
         end
         ST_MEASURE: begin
            if (s_valid) begin
               armed_d = armed_next;
               cnt_d   = cnt_inc;
               peak_d  = peak_new;
               // A crossing wins over a timeout landing on the same sample.
               if (crossing) begin
                  since_d = '0;
                  if (ncross_q == 8'(NCROSS - 1)) begin
                     state_d     = ST_REPORT;
                     r_period_d  = cnt_inc;
                     r_peak_d    = peak_new;
                     r_timeout_d = 1'b0;
                  end else begin
                     ncross_d = ncross_q + 8'd1;
                  end
               end else if (since_inc == TO_W'(TIMEOUT)) begin
                  state_d     = ST_REPORT;
                  r_period_d  = cnt_inc;
                  r_peak_d    = peak_new;
                  r_timeout_d = 1'b1;
               end else begin
                  since_d = since_inc;
               end
            end
         end
         ST_REPORT: begin
            if (r_ready) begin
               state_d = ST_IDLE;
               // Forget the terminating sample so it cannot open the next window.
               armed_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         since_q     <= '0;
         ncross_q    <= '0;
         peak_q      <= '0;
         armed_q     <= 1'b0;
         r_period_q  <= '0;
         r_peak_q    <= '0;
         r_timeout_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         since_q     <= since_d;
         ncross_q    <= ncross_d;
         peak_q      <= peak_d;
         armed_q     <= armed_d;
         r_period_q  <= r_period_d;
         r_peak_q    <= r_peak_d;
         r_timeout_q <= r_timeout_d;
      end
   end

   assign s_ready   = (state_q != ST_REPORT);
   assign r_valid   = (state_q == ST_REPORT);
   assign r_period  = r_period_q;
   assign r_peak    = r_peak_q;
   assign r_timeout = r_timeout_q;

endmodule

// File: tb/tb_tone_detector.sv
// -----------------------------------------------------------------------------
// tb_tone_detector
//
// Directed testbench for tone_detector (DATA_W=16, NCROSS=8, TIMEOUT=100).
// Covers reset values, square-wave period measurement, back-pressure on the
// result, timeout, peak of the most negative code, +/-30 noise, and an
// asynchronous reset in the middle of a measurement.
// -----------------------------------------------------------------------------
module tb_tone_detector;

   localparam int DATA_W  = 16;
   localparam int CNT_W   = 24;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [DATA_W-1:0] s_data = '0;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic              r_valid;
   logic              r_ready = 1'b0;
   logic [CNT_W-1:0]  r_period;
   logic [DATA_W-1:0] r_peak;
   logic              r_timeout;

   int n_checks = 0;
   int n_errors = 0;

   tone_detector #(
      .DATA_W (DATA_W),
      .NCROSS (8),
      .CNT_W  (CNT_W),
      .TIMEOUT(100),
      .HYST   (64)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .r_valid  (r_valid),
      .r_ready  (r_ready),
      .r_period (r_period),
      .r_peak   (r_peak),
      .r_timeout(r_timeout)
   );

   always #5 clk = ~clk;

`ifdef TONE_DET_HYST_EN
   localparam int TO_CROSS = 100;   // crossing sample must clear +HYST
`else
   localparam int TO_CROSS = 5;
`endif

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
      end else begin
         $display("ok   %s: %0d", tag, observed);
      end
   endtask

   // Offer one sample; returns #1 after the edge that accepted it.
   task automatic send(input int v);
      s_data  = 16'(v);
      s_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic handshake(input string tag);
      s_valid = 1'b0;
      r_ready = 1'b1;
      @(posedge clk);
      #1;
      r_ready = 1'b0;
      check({tag, " r_valid after handshake"}, 32'(r_valid), 32'd0);
      check({tag, " s_ready after handshake"}, 32'(s_ready), 32'd1);
   endtask

   task automatic check_result(input string tag, input int period, input int peak, input int tmo);
      check({tag, " r_valid"},   32'(r_valid),   32'd1);
      check({tag, " s_ready"},   32'(s_ready),   32'd0);
      check({tag, " r_period"},  32'(r_period),  32'(period));
      check({tag, " r_peak"},    32'(r_peak),    32'(peak));
      check({tag, " r_timeout"}, 32'(r_timeout), 32'(tmo));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " s_ready"},   32'(s_ready),   32'd1);
      check({tag, " r_valid"},   32'(r_valid),   32'd0);
      check({tag, " r_period"},  32'(r_period),  32'd0);
      check({tag, " r_peak"},    32'(r_peak),    32'd0);
      check({tag, " r_timeout"}, 32'(r_timeout), 32'd0);
   endtask

   // Square wave +/-1000 with period 20: ten low samples, then ten high.
   function automatic int sq(input int k);
      return (((k / 10) % 2) == 0) ? -1000 : 1000;
   endfunction

   initial begin
      // ---------------- reset ----------------
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst_n = 1'b1;

      // ---------------- square wave, with a gap in s_valid ----------------
      // First crossing at k=10 opens the window; the 8th following crossing is
      // at k=170, so the window spans 160 accepted samples.
      for (int k = 0; k <= 170; k++) begin
         send(sq(k));
         if (k == 100) idle(5);
         if (k == 169) check("square r_valid before last crossing", 32'(r_valid), 32'd0);
      end
      check_result("square", 160, 1000, 0);

      // ---------------- back-pressure on the result ----------------
      for (int i = 0; i < 10; i++) begin
         send(i * 50 - 200);
         check("stall s_ready",  32'(s_ready),  32'd0);
         check("stall r_valid",  32'(r_valid),  32'd1);
         check("stall r_period", 32'(r_period), 32'd160);
         check("stall r_peak",   32'(r_peak),   32'd1000);
      end
      handshake("square");

      // ---------------- timeout ----------------
      send(-100);
      send(TO_CROSS);
      for (int j = 1; j <= 100; j++) begin
         send(5);
         if (j == 99) check("timeout r_valid at 99", 32'(r_valid), 32'd0);
      end
      check_result("timeout", 100, TO_CROSS, 1);
      handshake("timeout");

      // ---------------- most negative sample in the window ----------------
      send(-1000);
      send(1000);
      send(-32768);
      send(1000);
      for (int j = 0; j < 7; j++) begin
         send(-1000);
         send(1000);
      end
      check_result("peak", 16, 32768, 0);
      handshake("peak");

      // ---------------- +/-30 noise ----------------
      for (int j = 0; j < 9; j++) begin
         send(-30);
         if (j == 8) check("noise r_valid before last", 32'(r_valid), 32'd0);
         send(30);
      end
`ifdef TONE_DET_HYST_EN
      check("noise hyst r_valid", 32'(r_valid), 32'd0);
      check("noise hyst s_ready", 32'(s_ready), 32'd1);
`else
      check_result("noise", 16, 30, 0);
      handshake("noise");
`endif

      // ---------------- reset mid-measurement ----------------
      // k=0..85 opens a window at k=10 and adds crossings at 30, 50, 70; the
      // last sample (k=85) is negative.
      for (int k = 0; k <= 85; k++) send(sq(k));
      rst_n = 1'b0;
      #1;
      check_reset_values("async reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      // Restart on a positive sample: with the predecessor cleared it cannot
      // cross, so the window opens at k=30 and closes at k=190.
      for (int k = 10; k <= 190; k++) begin
         send(sq(k));
         if (k == 189) check("post-reset r_valid before last", 32'(r_valid), 32'd0);
      end
      check_result("post-reset", 160, 1000, 0);
      handshake("post-reset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
